// File: rtl/uart_pkg.sv
// uart_pkg: shared UART parity modes, receiver state encoding and baud-divider helper.
package uart_pkg;
  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD = 1;
  localparam int PARITY_EVEN = 2;
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} rx_state_e;
  function automatic int clks_per_bit(input int freq, input int baud);
    return freq / baud;
  endfunction
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchroniser for an asynchronous input that idles high.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk)
    if (rst) {q, meta} <= 2'b11;
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver feeding a one-word valid/ready holding register.
// Define UART_RX_MAJORITY_EN for 2-of-3 voting around each mid-bit point.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ_HZ = 12000000,
  parameter int BAUD_RATE = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);
  localparam int CPB = clks_per_bit(CLOCK_FREQ_HZ, BAUD_RATE);
  localparam int HALF = CPB / 2;
  localparam int CW = $clog2(CPB + 1);
  localparam logic ODD = PARITY == PARITY_ODD;
  localparam logic [2:0] S_IDLE = ST_IDLE;
  localparam logic [2:0] S_START = ST_START;
  localparam logic [2:0] S_DATA = ST_DATA;
  localparam logic [2:0] S_PAR = ST_PARITY;
  localparam logic [2:0] S_STOP = ST_STOP;

  if (CPB < 4 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < PARITY_NONE || PARITY > PARITY_EVEN ||
      STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_cfg
    $error("uart_rx_param: illegal configuration");
  end

  logic            rx_s, bit_val, tick, commit, load, last_data;
  logic [2:0]      state;
  logic [CW-1:0]   cnt, tick_at;
  logic [3:0]      bit_cnt;
  logic [DATA_BITS-1:0] sh;
  logic            ferr, perr;

  uart_rx_sync u_sync (.clk(clk), .rst(rst), .d(rx), .q(rx_s));

`ifdef UART_RX_MAJORITY_EN
  localparam int LAG = 1;
  logic [1:0] votes;
  always_ff @(posedge clk)
    if (rst) votes <= 2'b11;
    else if (cnt == tick_at - CW'(2) || cnt == tick_at - CW'(1)) votes <= {votes[0], rx_s};
  assign bit_val = (votes[1] & votes[0]) | (rx_s & (votes[1] | votes[0]));
`else
  localparam int LAG = 0;
  assign bit_val = rx_s;
`endif

  // START counts from the falling edge; later bits count from the previous decision point
  assign tick_at = state == S_START ? CW'(HALF + LAG) : CW'(CPB - 1);
  assign tick = cnt == tick_at;
  assign last_data = bit_cnt == 4'(DATA_BITS - 1);
  assign commit = state == S_STOP && tick && bit_cnt == 4'(STOP_BITS - 1);
  assign load = commit && (!data_valid || data_ready);
  assign busy = state != S_IDLE;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt <= '0;
      bit_cnt <= '0;
      sh <= '0;
      ferr <= 1'b0;
      perr <= 1'b0;
      data_out <= '0;
      data_valid <= 1'b0;
      frame_err <= 1'b0;
      parity_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      cnt <= state == S_IDLE ? CW'(1) : tick ? '0 : cnt + CW'(1);
      case (state)
        S_IDLE: if (!rx_s) begin
          state <= S_START;
          bit_cnt <= '0;
          ferr <= 1'b0;
          perr <= 1'b0;
        end
        S_START: if (tick) state <= bit_val ? S_IDLE : S_DATA;
        S_DATA: if (tick) begin
          sh <= {bit_val, sh[DATA_BITS-1:1]};
          bit_cnt <= last_data ? '0 : bit_cnt + 4'd1;
          if (last_data) state <= PARITY == PARITY_NONE ? S_STOP : S_PAR;
        end
        S_PAR: if (tick) begin
          perr <= ^sh ^ bit_val ^ ODD;
          state <= S_STOP;
        end
        S_STOP: if (tick) begin
          ferr <= ferr | ~bit_val;
          bit_cnt <= bit_cnt + 4'd1;
          if (commit) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
      overrun <= commit && !load;
      if (load) begin
        data_out <= sh;
        frame_err <= ferr | ~bit_val;
        parity_err <= perr;
        data_valid <= 1'b1;
      end else if (data_valid && data_ready) data_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: randomized and directed checks of uart_rx_param against a frame-level model.
module tb_uart_rx_param;
  localparam int CPB_S = 1250;
  localparam int CPB_F = 104;
`ifdef UART_RX_MAJORITY_EN
  localparam int LAG = 1;
`else
  localparam int LAG = 0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_l [3];
  logic rdy [3];
  logic [7:0] dout [3];
  logic dv [3], fe [3], pe [3], ov [3], bz [3];
  logic dv_prev [3];
  logic [9:0] got_q [3][$];
  longint rise_cyc [3];
  int vcnt [3], ov_cnt [3];
  longint cyc = 0;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_param dut_slow (.clk(clk), .rst(rst), .rx(rx_l[0]), .data_out(dout[0]), .data_valid(dv[0]),
    .data_ready(rdy[0]), .frame_err(fe[0]), .parity_err(pe[0]), .overrun(ov[0]), .busy(bz[0]));
  uart_rx_param #(.BAUD_RATE(115200)) dut_fast (.clk(clk), .rst(rst), .rx(rx_l[1]), .data_out(dout[1]),
    .data_valid(dv[1]), .data_ready(rdy[1]), .frame_err(fe[1]), .parity_err(pe[1]), .overrun(ov[1]), .busy(bz[1]));
  uart_rx_param #(.BAUD_RATE(115200), .PARITY(2)) dut_even (.clk(clk), .rst(rst), .rx(rx_l[2]),
    .data_out(dout[2]), .data_valid(dv[2]), .data_ready(rdy[2]), .frame_err(fe[2]), .parity_err(pe[2]),
    .overrun(ov[2]), .busy(bz[2]));

  // transfer log: every accepted word as {frame_err, parity_err, data}
  always @(negedge clk)
    for (int i = 0; i < 3; i++) begin
      if (dv[i] === 1'b1 && rdy[i]) got_q[i].push_back({fe[i], pe[i], dout[i]});
      if (dv[i] === 1'b1 && dv_prev[i] !== 1'b1) rise_cyc[i] = cyc;
      if (dv[i] === 1'b1) vcnt[i]++;
      if (ov[i] === 1'b1) ov_cnt[i]++;
      dv_prev[i] = dv[i];
    end

  function automatic logic even_bad(input logic [7:0] d, input logic pbit);
    return ((32'($countones(d)) + 32'(pbit)) % 2) != 0;
  endfunction

  task automatic clear(input int l);
    got_q[l].delete();
    vcnt[l] = 0;
    ov_cnt[l] = 0;
    rise_cyc[l] = -1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic at_cyc(input longint c);
    do @(negedge clk); while (cyc < c);
  endtask

  // one frame on line l: start, 8 data bits LSB first, optional parity bit, one stop bit
  task automatic send(input int l, input logic [7:0] d, input bit par, input logic pbit,
                      input logic stop, output longint c0);
    int cpb = l == 0 ? CPB_S : CPB_F;
    logic [10:0] f = par ? {stop, pbit, d, 1'b0} : {1'b1, stop, d, 1'b0};
    int n = par ? 11 : 10;
    @(posedge clk); #1;
    c0 = cyc;
    for (int i = 0; i < n; i++) begin
      rx_l[l] = f[i];
      repeat (cpb) @(posedge clk);
      #1;
    end
    rx_l[l] = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      tests++;
      if ({dout[i], dv[i], fe[i], pe[i], ov[i], bz[i]} !== 13'd0) begin
        fails++;
        $display("FAIL reset_outputs[%0d]: got %h required 0", i, {dout[i], dv[i], fe[i], pe[i], ov[i], bz[i]});
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic;
    longint c0;
    clear(0);
    send(0, 8'h31, 0, 1'b0, 1'b1, c0);
    idle(5);
    tests++;
    if (rise_cyc[0] !== c0 + 2 + 11876 + LAG) begin
      fails++;
      $display("FAIL basic_latency: got %0d required %0d", rise_cyc[0] - c0, 2 + 11876 + LAG);
    end
    tests++;
    if (vcnt[0] !== 1) begin fails++; $display("FAIL basic_valid_cycles: got %0d required 1", vcnt[0]); end
    tests++;
    if (got_q[0].size() != 1 || got_q[0][0] !== {2'b00, 8'h31}) begin
      fails++;
      $display("FAIL basic_word: got %0d words first %h required 1 word 031", got_q[0].size(),
               got_q[0].size() > 0 ? got_q[0][0] : 10'h3ff);
    end
    tests++;
    if (ov_cnt[0] !== 0) begin fails++; $display("FAIL basic_overrun: got %0d required 0", ov_cnt[0]); end
  endtask

  task automatic test_glitch;
    longint c0;
    clear(0);
    @(posedge clk); #1;
    c0 = cyc;
    rx_l[0] = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    rx_l[0] = 1'b1;
    at_cyc(c0 + 2 + 625 + LAG);
    tests++;
    if (bz[0] !== 1'b1) begin fails++; $display("FAIL glitch_busy_high: got %b required 1", bz[0]); end
    at_cyc(c0 + 2 + 626 + LAG);
    tests++;
    if (bz[0] !== 1'b0) begin fails++; $display("FAIL glitch_busy_low: got %b required 0", bz[0]); end
    idle(50);
    tests++;
    if (vcnt[0] !== 0) begin fails++; $display("FAIL glitch_no_word: got %0d valid cycles required 0", vcnt[0]); end
    send(0, 8'h35, 0, 1'b0, 1'b1, c0);
    idle(5);
    tests++;
    if (got_q[0].size() != 1 || got_q[0][0] !== {2'b00, 8'h35}) begin
      fails++;
      $display("FAIL glitch_next_word: got %0d words required 1 word 035", got_q[0].size());
    end
  endtask

  task automatic test_parity;
    longint c0;
    for (int k = 0; k < 2; k++) begin
      logic pbit = k[0];
      logic [9:0] exp = {1'b0, even_bad(8'h07, pbit), 8'h07};
      clear(2);
      send(2, 8'h07, 1, pbit, 1'b1, c0);
      idle(5);
      tests++;
      if (got_q[2].size() != 1 || got_q[2][0] !== exp) begin
        fails++;
        $display("FAIL parity_pbit%0d: got %0d words first %h required %h", k, got_q[2].size(),
                 got_q[2].size() > 0 ? got_q[2][0] : 10'h3ff, exp);
      end
    end
  endtask

  task automatic test_frame_err;
    longint c0;
    clear(1);
    send(1, 8'h32, 0, 1'b0, 1'b0, c0);
    idle(3 * CPB_F);
    tests++;
    if (got_q[1].size() < 1 || got_q[1][0] !== {2'b10, 8'h32}) begin
      fails++;
      $display("FAIL frame_err_word: got %h required 232", got_q[1].size() > 0 ? got_q[1][0] : 10'h3ff);
    end
    tests++;
    if (got_q[1].size() != 1) begin fails++; $display("FAIL frame_err_spurious: got %0d words required 1", got_q[1].size()); end
  endtask

  task automatic test_overrun;
    longint c0;
    clear(1);
    rdy[1] = 1'b0;
    send(1, 8'h31, 0, 1'b0, 1'b1, c0);
    tests++;
    if (ov_cnt[1] !== 0) begin fails++; $display("FAIL overrun_first: got %0d required 0", ov_cnt[1]); end
    send(1, 8'h32, 0, 1'b0, 1'b1, c0);
    idle(5);
    tests++;
    if (ov_cnt[1] !== 1) begin fails++; $display("FAIL overrun_pulse: got %0d cycles required 1", ov_cnt[1]); end
    tests++;
    if ({dv[1], fe[1], pe[1], dout[1]} !== {3'b100, 8'h31}) begin
      fails++;
      $display("FAIL overrun_held: got %h required 431", {dv[1], fe[1], pe[1], dout[1]});
    end
    @(posedge clk); #1;
    rdy[1] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (dv[1] !== 1'b0) begin fails++; $display("FAIL overrun_drop_valid: got %b required 0", dv[1]); end
    tests++;
    if (got_q[1].size() != 1 || got_q[1][0] !== {2'b00, 8'h31}) begin
      fails++;
      $display("FAIL overrun_transfer: got %0d words required 1 word 031", got_q[1].size());
    end
  endtask

  task automatic test_reset_mid;
    longint c0;
    clear(1);
    fork
      send(1, 8'hF9, 0, 1'b0, 1'b1, c0);
      begin
        repeat (1 + 4 * CPB_F + 50) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if ({dout[1], dv[1], fe[1], pe[1], ov[1], bz[1]} !== 13'd0) begin
          fails++;
          $display("FAIL reset_mid_outputs: got %h required 0", {dout[1], dv[1], fe[1], pe[1], ov[1], bz[1]});
        end
      end
    join
    idle(20);
    tests++;
    if (vcnt[1] !== 0) begin fails++; $display("FAIL reset_mid_no_word: got %0d valid cycles required 0", vcnt[1]); end
    send(1, 8'h34, 0, 1'b0, 1'b1, c0);
    idle(5);
    tests++;
    if (got_q[1].size() != 1 || got_q[1][0] !== {2'b00, 8'h34}) begin
      fails++;
      $display("FAIL reset_mid_next: got %0d words required 1 word 034", got_q[1].size());
    end
  endtask

  // random words, parity bits and stop errors; gaps of 0..3 cycles make frames back to back
  task automatic test_random(input int l, input int n);
    logic [9:0] exp_q [$];
    longint c0;
    clear(l);
    for (int k = 0; k < n; k++) begin
      logic [7:0] d = 8'($urandom);
      logic pbit = 1'($urandom);
      logic stop = $urandom_range(0, 3) != 0;
      send(l, d, l == 2, pbit, stop, c0);
      exp_q.push_back({~stop, l == 2 ? even_bad(d, pbit) : 1'b0, d});
      repeat (stop ? $urandom_range(0, 3) : 2 * CPB_F) @(posedge clk);
    end
    idle(10);
    tests++;
    if (got_q[l].size() != exp_q.size()) begin
      fails++;
      $display("FAIL random%0d_count: got %0d words required %0d", l, got_q[l].size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < got_q[l].size(); k++) begin
      tests++;
      if (got_q[l][k] !== exp_q[k]) begin
        fails++;
        $display("FAIL random%0d_word%0d: got %h required %h", l, k, got_q[l][k], exp_q[k]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rx_l[i] = 1'b1;
      rdy[i] = 1'b1;
      dv_prev[i] = 1'b0;
      vcnt[i] = 0;
      ov_cnt[i] = 0;
      rise_cyc[i] = -1;
    end
    test_reset;
    test_basic;
    test_glitch;
    test_parity;
    test_frame_err;
    test_overrun;
    test_reset_mid;
    test_random(1, 12);
    test_random(2, 12);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
- Parametrised UART receiver; successor to the fixed 8N1 LED-toggle receiver on the icestick top level.
- Configurable data width, parity and stop bits; rejects false start bits; reports framing, parity and overrun errors.
- Delivers each received word on a valid/ready handshake into a one-word holding register.
- Sits between the RX pin and command decoders (LED control, future register interface).

Parameters:
CLOCK_FREQ_HZ, 12000000, system clock frequency.
BAUD_RATE, 9600, line rate; CLKS_PER_BIT = CLOCK_FREQ_HZ/BAUD_RATE (1250), HALF = CLKS_PER_BIT/2 (625).
DATA_BITS, 8, data bits per frame, legal range 5..9, LSB first.
PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
STOP_BITS, 1, number of stop bits: 1 or 2.

Ports:
clk  in  1  system clock; one clock domain, all logic on its rising edge.
rst  in  1  synchronous, active-high reset.
rx  in  1  asynchronous serial input; idle high.
data_out  out  DATA_BITS  received word, valid while data_valid=1.
data_valid  out  1  holding register full.
data_ready  in  1  consumer accepts; transfer occurs on data_valid & data_ready.
frame_err  out  1  a stop-bit sample was 0; qualified by data_valid.
parity_err  out  1  parity mismatch; qualified by data_valid; always 0 when PARITY=0.
overrun  out  1  one-cycle pulse; a completed frame was dropped because the holding register was full.
busy  out  1  high while the FSM is not in IDLE.

Behaviour:
- Reset values:
  - data_out=0; data_valid, frame_err, parity_err, overrun and busy all 0.
  - FSM in IDLE; bit counters 0; both synchroniser flops 1.
- rx passes through a 2-flop synchroniser to rx_s. The rx pin reaches rx_s 2 cycles later.
- A cycle counter runs from the cycle in which IDLE sees rx_s=0 (t=0). Bit k is sampled at t = k*CLKS_PER_BIT + HALF, with k=0 for the start bit.
- IDLE: when rx_s=0, go to START with the counter cleared.
- START: sample at t=HALF.
  - Sample 1 (glitch): return to IDLE with no output and no error.
  - Sample 0: go to DATA.
- DATA: take DATA_BITS samples, shifting in LSB first. Then go to PARITY if PARITY!=0, else STOP.
- PARITY: sample one bit. parity_err_int = XOR of the data bits, the parity bit and (PARITY==1).
- STOP: take STOP_BITS samples. frame_err_int = OR of (sample==0).
  - At the last stop sample (commit cycle), the FSM returns to IDLE in the same cycle.
  - A line still low after a framing error (break) is treated as a new start bit.
- Commit rules:
  - If data_valid=0, or data_valid & data_ready in the commit cycle, load data_out, frame_err and parity_err and set data_valid next cycle. A simultaneous accept and commit therefore keeps data_valid high with the new word.
  - Otherwise the new frame is discarded: overrun pulses for 1 cycle and the held word and flags are unchanged.
- Handshake: on data_valid & data_ready with no commit, data_valid=0 next cycle. data_out and the flags hold their values while data_valid=1 and data_ready=0.
- Latency: data_valid rises 1 cycle after the commit cycle. For 8N1 the commit is at t=11875, so data_valid rises at t=11876.
- Reset mid-frame: the frame is aborted, no data_valid is produced, and all state returns to reset values.
- Elaboration check: CLKS_PER_BIT >= 4, plus the legal ranges of DATA_BITS, PARITY and STOP_BITS.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined:
  - Each bit, including start and stop bits, is sampled at offsets HALF-1, HALF and HALF+1.
  - The value used is the 2-of-3 majority, decided at HALF+1, so all decisions and data_valid move 1 cycle later.
  - Start-bit rejection uses the voted value.
- Undefined: a single sample at HALF; behaviour exactly as above.

Decomposition:
- Package uart_pkg:
  - Parity mode constants PARITY_NONE/ODD/EVEN.
  - FSM state enum IDLE/START/DATA/PARITY/STOP.
  - Function clks_per_bit(freq, baud).
- Sub-module uart_rx_sync: 2-flop synchroniser with reset value 1, reusable by the TX-loopback and future ports.

Test Plan:
- 8N1 defaults, send 0x31, data_ready=1 -> data_valid for exactly 1 cycle at t=11876; data_out=0x31; frame_err=0, parity_err=0, overrun=0.
- rx low pulse of 300 cycles -> busy high until t=625, then 0; no data_valid; the next frame 0x35 is received correctly.
- PARITY=2, send 0x07 with parity bit 0 (correct value is 1) -> data_out=0x07, parity_err=1. Resend with parity bit 1 -> parity_err=0.
- Send 0x32 with the stop bit driven 0 -> data_valid with data_out=0x32, frame_err=1; rx then returning high yields no spurious word.
- data_ready=0, send 0x31 then 0x32 -> overrun pulses once at the second commit; data_out stays 0x31. Raising data_ready drops data_valid next cycle.
- rst asserted for 1 cycle during data bit 3 -> all outputs 0 and no data_valid for that frame; the next frame 0x34 is received correctly.
